// File: rtl/mem_access_unit.sv
// Single-request load/store responder with programmable wait states feeding a register file write port.
// Optional feature: define ACCESS_CHECK_EN to flag out-of-range addresses on err instead of wrapping.
module mem_access_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [2:0]        rsp_reg,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err
);

  // state   | meaning
  // IDLE    | ready for a request, req_ready high
  // WAIT    | counting down wait states for the latched request
  // RESP    | one-cycle completion pulse, store already committed
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_rd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_rd;
  logic [IW-1:0]     idx;
  logic              in_range;
  logic              commit;

  // With LAT=0 the request completes on its accept edge, so use the live fields in IDLE.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_write = req_write;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_rd    = req_rd;
    end else begin
      sel_write = lat_write;
      sel_addr  = lat_addr;
      sel_wdata = lat_wdata;
      sel_rd    = lat_rd;
    end
  end

  assign idx = IW'(32'(sel_addr) % 32'(DEPTH));

`ifdef ACCESS_CHECK_EN
  logic err_q;
  assign in_range = (32'(sel_addr) < 32'(DEPTH));
  assign err      = err_q;
`else
  assign in_range = 1'b1;
  assign err      = 1'b0;
`endif

  // True on the edge that enters RESP; reset suppresses a pending commit.
  assign commit = !reset &&
                  (((state == ST_IDLE) && req_valid && (LAT == 0)) ||
                   ((state == ST_WAIT) && (cnt == 4'd1)));

  always_ff @(posedge clk) begin
    if (commit && sel_write && in_range)
      mem[idx] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_reg   <= '0;
      rsp_data  <= '0;
`ifdef ACCESS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
`ifdef ACCESS_CHECK_EN
      err_q     <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_rd    <= req_rd;
            cnt       <= 4'(LAT);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (LAT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        rsp_valid <= 1'b1;
        if (!sel_write) begin
          rsp_we   <= in_range;
          rsp_reg  <= sel_rd;
          rsp_data <= in_range ? mem[idx] : '0;
        end
`ifdef ACCESS_CHECK_EN
        err_q <= !in_range;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a LAT=2/DEPTH=256 instance and a LAT=0/DEPTH=16 instance
// checked against an array model of memory and response holding.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid = 1'b0, a_write = 1'b0, a_ready, a_rsp_valid, a_rsp_we, a_busy, a_err;
  logic [7:0] a_addr = '0, a_wdata = '0, a_rsp_data;
  logic [2:0] a_rd = '0, a_rsp_reg;
  logic       b_valid = 1'b0, b_write = 1'b0, b_ready, b_rsp_valid, b_rsp_we, b_busy, b_err;
  logic [7:0] b_addr = '0, b_wdata = '0, b_rsp_data;
  logic [2:0] b_rd = '0, b_rsp_reg;

  mem_access_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LAT(2)) u_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_rd(a_rd), .rsp_valid(a_rsp_valid),
    .rsp_we(a_rsp_we), .rsp_reg(a_rsp_reg), .rsp_data(a_rsp_data), .busy(a_busy), .err(a_err));

  mem_access_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .LAT(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_rd(b_rd), .rsp_valid(b_rsp_valid),
    .rsp_we(b_rsp_we), .rsp_reg(b_rsp_reg), .rsp_data(b_rsp_data), .busy(b_busy), .err(b_err));

  int checks = 0;
  int errors = 0;

  logic [7:0] model_a [256];
  logic [7:0] model_b [16];
  logic [2:0] last_reg [2];
  logic [7:0] last_data [2];

  function automatic int lat_of(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(int u);
    return (u == 0) ? 256 : 16;
  endfunction

  function automatic bit in_rng(int u, logic [7:0] ad);
`ifdef ACCESS_CHECK_EN
    return int'(ad) < depth_of(u);
`else
    return (u >= 0) || (ad != ad);
`endif
  endfunction

  function automatic logic [7:0] mem_rd(int u, logic [7:0] ad);
    int i;
    i = int'(ad) % depth_of(u);
    return (u == 0) ? model_a[i] : model_b[i];
  endfunction

  task automatic mem_wr(input int u, input logic [7:0] ad, input logic [7:0] d);
    int i;
    i = int'(ad) % depth_of(u);
    if (in_rng(u, ad)) begin
      if (u == 0) model_a[i] = d;
      else        model_b[i] = d;
    end
  endtask

  task automatic drive(input int u, input logic v, input logic w, input logic [7:0] ad,
                       input logic [7:0] wd, input logic [2:0] rd);
    if (u == 0) begin a_valid = v; a_write = w; a_addr = ad; a_wdata = wd; a_rd = rd; end
    else        begin b_valid = v; b_write = w; b_addr = ad; b_wdata = wd; b_rd = rd; end
  endtask

  task automatic sample(input int u, output logic rv, output logic we, output logic er,
                        output logic rdy, output logic bsy, output logic [2:0] rg,
                        output logic [7:0] dt);
    if (u == 0) begin rv = a_rsp_valid; we = a_rsp_we; er = a_err; rdy = a_ready; bsy = a_busy; rg = a_rsp_reg; dt = a_rsp_data; end
    else        begin rv = b_rsp_valid; we = b_rsp_we; er = b_err; rdy = b_ready; bsy = b_busy; rg = b_rsp_reg; dt = b_rsp_data; end
  endtask

  // Issues one request, scrambles the fields right after acceptance, and reports what the DUT showed.
  task automatic transact(input int u, input logic w, input logic [7:0] ad, input logic [7:0] wd,
                          input logic [2:0] rd, output int lat, output logic rv, output logic we,
                          output logic er, output logic rdy, output logic [2:0] rg,
                          output logic [7:0] dt, output logic rv_n, output logic [7:0] dt_n);
    logic bsy, t_we, t_er, t_rdy, t_bsy;
    logic [2:0] t_rg;
    int k;
    k = 0;
    @(negedge clk);
    sample(u, rv, we, er, rdy, bsy, rg, dt);
    while (!rdy && k < 50) begin
      @(negedge clk);
      sample(u, rv, we, er, rdy, bsy, rg, dt);
      k++;
    end
    drive(u, 1'b1, w, ad, wd, rd);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
    lat = 0;
    sample(u, rv, we, er, rdy, bsy, rg, dt);
    while (!rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(u, rv, we, er, rdy, bsy, rg, dt);
    end
    @(posedge clk); #1;
    sample(u, rv_n, t_we, t_er, t_rdy, t_bsy, t_rg, dt_n);
  endtask

  task automatic test_reset();
    logic rv, we, er, rdy, bsy;
    logic [2:0] rg;
    logic [7:0] dt;
    #3 reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      sample(u, rv, we, er, rdy, bsy, rg, dt);
      checks++; if (rv !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid u%0d got %b exp 0", u, rv); end
      checks++; if (we !== 1'b0)  begin errors++; $display("FAIL reset_rsp_we u%0d got %b exp 0", u, we); end
      checks++; if (er !== 1'b0)  begin errors++; $display("FAIL reset_err u%0d got %b exp 0", u, er); end
      checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy u%0d got %b exp 0", u, bsy); end
      checks++; if (rg !== 3'd0)  begin errors++; $display("FAIL reset_rsp_reg u%0d got %0h exp 0", u, rg); end
      checks++; if (dt !== 8'd0)  begin errors++; $display("FAIL reset_rsp_data u%0d got %0h exp 0", u, dt); end
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      sample(u, rv, we, er, rdy, bsy, rg, dt);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_reset_ready u%0d got %b exp 1", u, rdy); end
      last_reg[u] = 3'd0;
      last_data[u] = 8'd0;
    end
  endtask

  task automatic test_preload();
    int lat;
    logic rv, we, er, rdy, rv_n;
    logic [2:0] rg;
    logic [7:0] dt, dt_n, d;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < ((u == 0) ? 32 : 16); i++) begin
        d = 8'($urandom);
        transact(u, 1'b1, 8'(i), d, 3'd0, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
        mem_wr(u, 8'(i), d);
        checks++; if (lat !== lat_of(u)) begin errors++; $display("FAIL preload_latency u%0d got %0d exp %0d", u, lat, lat_of(u)); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL preload_we u%0d got %b exp 0", u, we); end
        checks++; if (rv_n !== 1'b0) begin errors++; $display("FAIL preload_valid_drop u%0d got %b exp 0", u, rv_n); end
      end
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic rv, we, er, rdy, rv_n;
    logic [2:0] rg;
    logic [7:0] dt, dt_n;
    transact(0, 1'b1, 8'h10, 8'hA5, 3'd0, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    mem_wr(0, 8'h10, 8'hA5);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_store_latency got %0d exp 2", lat); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL sl_store_we got %b exp 0", we); end
    transact(0, 1'b0, 8'h10, 8'h00, 3'd3, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_load_latency got %0d exp 2", lat); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sl_load_we got %b exp 1", we); end
    checks++; if (rg !== 3'd3) begin errors++; $display("FAIL sl_load_reg got %0h exp 3", rg); end
    checks++; if (dt !== 8'hA5) begin errors++; $display("FAIL sl_load_data got %0h exp a5", dt); end
    checks++; if (dt_n !== 8'hA5) begin errors++; $display("FAIL sl_data_hold got %0h exp a5", dt_n); end
    checks++; if (rv_n !== 1'b0) begin errors++; $display("FAIL sl_valid_drop got %b exp 0", rv_n); end
    last_reg[0] = 3'd3;
    last_data[0] = 8'hA5;
  endtask

  task automatic test_lat0();
    int lat;
    logic rv, we, er, rdy, rv_n;
    logic [2:0] rg;
    logic [7:0] dt, dt_n, e;
    e = mem_rd(1, 8'h05);
    transact(1, 1'b0, 8'h05, 8'h00, 3'd4, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    checks++; if (lat !== 0) begin errors++; $display("FAIL lat0_latency got %0d exp 0", lat); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL lat0_valid got %b exp 1", rv); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL lat0_we got %b exp 1", we); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lat0_ready got %b exp 0", rdy); end
    checks++; if (dt !== e) begin errors++; $display("FAIL lat0_data got %0h exp %0h", dt, e); end
    last_reg[1] = 3'd4;
    last_data[1] = e;
  endtask

  task automatic test_hold_busy();
    logic [7:0] x;
    logic switched;
    int pulses, p1, p2;
    logic we1, we2;
    logic [2:0] rg2;
    logic [7:0] dt2;
    x = ~mem_rd(0, 8'h08);
    switched = 1'b0; pulses = 0; p1 = -1; p2 = -1; we1 = 1'bx; we2 = 1'bx; rg2 = 'x; dt2 = 'x;
    @(negedge clk);
    while (!a_ready) @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h08, x, 3'd0);
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        pulses++;
        if (pulses == 1) begin p1 = j; we1 = a_rsp_we; end
        else begin p2 = j; we2 = a_rsp_we; rg2 = a_rsp_reg; dt2 = a_rsp_data; a_valid = 1'b0; end
      end
      if (!switched && a_ready) begin
        drive(0, 1'b1, 1'b0, 8'h08, 8'h00, 3'd5);
        switched = 1'b1;
      end else if (!switched) begin
        drive(0, 1'b1, 1'($urandom), 8'h40 + 8'($urandom_range(0, 63)), 8'($urandom), 3'($urandom));
      end
    end
    a_valid = 1'b0;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL busy_pulse_count got %0d exp 2", pulses); end
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL busy_first_we got %b exp 0", we1); end
    checks++; if (p2 - p1 !== 4) begin errors++; $display("FAIL busy_throughput got %0d exp 4", p2 - p1); end
    checks++; if (we2 !== 1'b1) begin errors++; $display("FAIL busy_second_we got %b exp 1", we2); end
    checks++; if (rg2 !== 3'd5) begin errors++; $display("FAIL busy_second_reg got %0h exp 5", rg2); end
    checks++; if (dt2 !== x) begin errors++; $display("FAIL busy_second_data got %0h exp %0h", dt2, x); end
    mem_wr(0, 8'h08, x);
    last_reg[0] = 3'd5;
    last_data[0] = x;
  endtask

  task automatic test_reset_wait();
    int lat, seen;
    logic rv, we, er, rdy, bsy, rv_n;
    logic [2:0] rg;
    logic [7:0] dt, dt_n;
    transact(0, 1'b1, 8'h20, 8'h11, 3'd0, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    mem_wr(0, 8'h20, 8'h11);
    @(negedge clk);
    while (!a_ready) @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h20, 8'h3C, 3'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    #2 reset = 1'b1;
    #1;
    sample(0, rv, we, er, rdy, bsy, rg, dt);
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL rw_busy got %b exp 0", bsy); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rw_ready got %b exp 1", rdy); end
    checks++; if (rg !== 3'd0) begin errors++; $display("FAIL rw_rsp_reg got %0h exp 0", rg); end
    checks++; if (dt !== 8'd0) begin errors++; $display("FAIL rw_rsp_data got %0h exp 0", dt); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_rsp_valid || a_rsp_we) seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_rsp_valid || a_rsp_we) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rw_no_response got %0d exp 0", seen); end
    for (int u = 0; u < 2; u++) begin last_reg[u] = 3'd0; last_data[u] = 8'd0; end
    transact(0, 1'b0, 8'h20, 8'h00, 3'd2, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    checks++; if (dt !== 8'h11) begin errors++; $display("FAIL rw_old_value got %0h exp 11", dt); end
    last_reg[0] = 3'd2;
    last_data[0] = 8'h11;
  endtask

  task automatic test_wrap();
    int lat;
    logic rv, we, er, rdy, rv_n;
    logic [2:0] rg;
    logic [7:0] dt, dt_n, old5;
    transact(1, 1'b1, 8'h00, 8'h77, 3'd0, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    mem_wr(1, 8'h00, 8'h77);
    transact(1, 1'b0, 8'h20, 8'h00, 3'd6, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
`ifdef ACCESS_CHECK_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL wrap_err got %b exp 1", er); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wrap_we got %b exp 0", we); end
    checks++; if (dt !== 8'h00) begin errors++; $display("FAIL wrap_data got %0h exp 0", dt); end
    last_data[1] = 8'h00;
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", er); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL wrap_we got %b exp 1", we); end
    checks++; if (dt !== 8'h77) begin errors++; $display("FAIL wrap_data got %0h exp 77", dt); end
    last_data[1] = 8'h77;
`endif
    last_reg[1] = 3'd6;
    old5 = mem_rd(1, 8'h05);
    transact(1, 1'b1, 8'h25, 8'h99, 3'd0, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
    transact(1, 1'b0, 8'h05, 8'h00, 3'd1, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
`ifdef ACCESS_CHECK_EN
    checks++; if (dt !== old5) begin errors++; $display("FAIL wrap_store_blocked got %0h exp %0h", dt, old5); end
`else
    checks++; if (dt !== 8'h99) begin errors++; $display("FAIL wrap_store_aliased got %0h exp 99", dt); end
`endif
    mem_wr(1, 8'h25, 8'h99);
    last_reg[1] = 3'd1;
    last_data[1] = dt;
  endtask

  task automatic test_random();
    int u, lat;
    logic w, ir, rv, we, er, rdy, rv_n, e_we, e_er;
    logic [2:0] rd, rg, e_rg;
    logic [7:0] ad, wd, dt, dt_n, e_dt;
    for (int n = 0; n < 60; n++) begin
      u  = $urandom_range(0, 1);
      w  = 1'($urandom);
      ad = (u == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      wd = 8'($urandom);
      rd = 3'($urandom);
      ir = in_rng(u, ad);
      if (w) begin
        mem_wr(u, ad, wd);
        e_we = 1'b0; e_rg = last_reg[u]; e_dt = last_data[u];
      end else begin
        e_we = ir; e_rg = rd; e_dt = ir ? mem_rd(u, ad) : 8'h00;
      end
      e_er = ~ir;
      transact(u, w, ad, wd, rd, lat, rv, we, er, rdy, rg, dt, rv_n, dt_n);
      checks++; if (lat !== lat_of(u)) begin errors++; $display("FAIL rnd_latency n%0d u%0d got %0d exp %0d", n, u, lat, lat_of(u)); end
      checks++; if (we !== e_we) begin errors++; $display("FAIL rnd_we n%0d u%0d got %b exp %b", n, u, we, e_we); end
      checks++; if (er !== e_er) begin errors++; $display("FAIL rnd_err n%0d u%0d got %b exp %b", n, u, er, e_er); end
      checks++; if (rg !== e_rg) begin errors++; $display("FAIL rnd_reg n%0d u%0d got %0h exp %0h", n, u, rg, e_rg); end
      checks++; if (dt !== e_dt) begin errors++; $display("FAIL rnd_data n%0d u%0d got %0h exp %0h", n, u, dt, e_dt); end
      checks++; if (rv_n !== 1'b0) begin errors++; $display("FAIL rnd_valid_drop n%0d u%0d got %b exp 0", n, u, rv_n); end
      checks++; if (dt_n !== e_dt) begin errors++; $display("FAIL rnd_data_hold n%0d u%0d got %0h exp %0h", n, u, dt_n, e_dt); end
      last_reg[u] = e_rg;
      last_data[u] = e_dt;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_store_load();
    test_lat0();
    test_hold_busy();
    test_reset_wait();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors_so_far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
